// File: rtl/instr_fetch_if.sv
// Instruction fetch interface: core-side request/response and the
// byte-wide program memory port, grouped so one bundle connects the stage.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int NBYTES = 4
);
    logic [ADDR_W-1:0]   pc;
    logic                fetch_req;
    logic                flush;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [7:0]          mem_rdata;
    logic [8*NBYTES-1:0] opbus;
    logic                instr_valid;
    logic                busy;
    logic [7:0]          miss_count;

    // Environment side: program counter, control and memory data source
    modport master (
        output pc, fetch_req, flush, mem_rdata,
        input  mem_addr, mem_rd, opbus, instr_valid, busy, miss_count
    );

    // Fetch stage side
    modport slave (
        input  pc, fetch_req, flush, mem_rdata,
        output mem_addr, mem_rd, opbus, instr_valid, busy, miss_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads NBYTES consecutive program bytes for the
// requested pc, assembles them off to the side, and publishes the whole word
// on opbus at once. A one-entry tag lets a repeated pc complete with no
// memory traffic. All outputs are registered.
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int NBYTES  = 4,
    parameter int MEM_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);
    localparam int OP_W  = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, VALID} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic [ADDR_W-1:0]  tag, tag_nxt;
    logic               tag_valid, tag_valid_nxt;
    logic [ADDR_W-1:0]  mem_addr, mem_addr_nxt;
    logic               mem_rd, mem_rd_nxt;
    logic               instr_valid, instr_valid_nxt;
    logic               busy, busy_nxt;
    logic [IDX_W-1:0]   issue_idx, issue_idx_nxt;
    logic [IDX_W-1:0]   ret_idx, ret_idx_nxt;
    logic [MEM_LAT-1:0] ret_pipe, ret_pipe_nxt;
    logic [OP_W-1:0]    shadow, shadow_nxt;
    logic [OP_W-1:0]    opbus, opbus_nxt;
    logic [7:0]         miss_count, miss_count_nxt;
    logic               ret_now;
    logic               hit;

    // Register bank: all state advances on the rising edge, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc_q        <= '0;
            tag         <= '0;
            tag_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            issue_idx   <= '0;
            ret_idx     <= '0;
            // Clearing the return pipe is what discards late bytes after reset.
            ret_pipe    <= '0;
            // NOTE: the shadow word is reset too; it is small, and a defined value keeps opbus free of X.
            shadow      <= '0;
            opbus       <= '0;
            miss_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            pc_q        <= pc_nxt;
            tag         <= tag_nxt;
            tag_valid   <= tag_valid_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_rd      <= mem_rd_nxt;
            instr_valid <= instr_valid_nxt;
            busy        <= busy_nxt;
            issue_idx   <= issue_idx_nxt;
            ret_idx     <= ret_idx_nxt;
            ret_pipe    <= ret_pipe_nxt;
            shadow      <= shadow_nxt;
            opbus       <= opbus_nxt;
            miss_count  <= miss_count_nxt;
        end
    end

    // Next-state and next-output logic for the fetch sequence
    always_comb begin
        // NOTE: every target is given its hold value first so no path can infer a latch.
        state_nxt       = state;
        pc_nxt          = pc_q;
        tag_nxt         = tag;
        tag_valid_nxt   = tag_valid;
        mem_addr_nxt    = mem_addr;
        mem_rd_nxt      = mem_rd;
        instr_valid_nxt = instr_valid;
        busy_nxt        = busy;
        issue_idx_nxt   = issue_idx;
        ret_idx_nxt     = ret_idx;
        shadow_nxt      = shadow;
        opbus_nxt       = opbus;
        miss_count_nxt  = miss_count;
        // Each read strobe travels MEM_LAT stages; the oldest stage marks a returning byte.
        ret_pipe_nxt    = MEM_LAT'({ret_pipe, mem_rd});
        ret_now         = ret_pipe[MEM_LAT-1];
        hit             = tag_valid && (bus.pc == tag);

        if (bus.flush) begin
            // Abort wins over everything, including a same-cycle request.
            state_nxt       = IDLE;
            instr_valid_nxt = 1'b0;
            busy_nxt        = 1'b0;
            mem_rd_nxt      = 1'b0;
            tag_valid_nxt   = 1'b0;
            ret_pipe_nxt    = '0;
        end else begin
            if (ret_now) begin
                shadow_nxt[ret_idx*8 +: 8] = bus.mem_rdata;
                ret_idx_nxt                = ret_idx + IDX_W'(1);
            end

            case (state)
                IDLE, VALID: begin
                    if (bus.fetch_req) begin
                        pc_nxt = bus.pc;
                        if (hit) begin
                            state_nxt       = VALID;
                            instr_valid_nxt = 1'b1;
                        end else begin
                            state_nxt       = ISSUE;
                            instr_valid_nxt = 1'b0;
                            busy_nxt        = 1'b1;
                            mem_rd_nxt      = 1'b1;
                            mem_addr_nxt    = bus.pc;
                            issue_idx_nxt   = '0;
                            ret_idx_nxt     = '0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_idx == LAST_IDX) begin
                        state_nxt  = DRAIN;
                        mem_rd_nxt = 1'b0;
                    end else begin
                        issue_idx_nxt = issue_idx + IDX_W'(1);
                        mem_addr_nxt  = mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The last byte is merged on its way in, so opbus never shows a partial word.
                    if (ret_now && (ret_idx == LAST_IDX)) begin
                        state_nxt       = VALID;
                        opbus_nxt       = shadow_nxt;
                        instr_valid_nxt = 1'b1;
                        busy_nxt        = 1'b0;
                        tag_nxt         = pc_q;
                        tag_valid_nxt   = 1'b1;
                        miss_count_nxt  = miss_count + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr;
    assign bus.mem_rd      = mem_rd;
    assign bus.opbus       = opbus;
    assign bus.instr_valid = instr_valid;
    assign bus.busy        = busy;
    assign bus.miss_count  = miss_count;
endmodule
